// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the signals between the instruction-fetch stage and its
// surroundings: hazard/branch control, instruction memory and the IF/ID
// pipeline register outputs.
//
//   stall          hazard unit: hold PC and IF/ID
//   flush          branch taken in decode: redirect PC, squash IF/ID
//   branch_target  redirect address, valid when flush=1
//   imem_addr      instruction-memory address (the PC register)
//   imem_data      instruction word, combinational read of imem_addr
//   ifid_instr     registered instruction to decode
//   ifid_pc_plus2  registered PC+2 of that instruction
//   ifid_valid     IF/ID holds a real instruction
//   hlt            fetch halted
//   fetch_count    saturating count of valid instructions delivered
//
// modport master : the fetch stage itself
// modport slave  : the surrounding CPU / memory / testbench
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);
   logic               stall;
   logic               flush;
   logic [ADDR_W-1:0]  branch_target;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic [INSTR_W-1:0] ifid_instr;
   logic [ADDR_W-1:0]  ifid_pc_plus2;
   logic               ifid_valid;
   logic               hlt;
   logic [15:0]        fetch_count;

   modport master (
      input  stall, flush, branch_target, imem_data,
      output imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, hlt, fetch_count
   );

   modport slave (
      output stall, flush, branch_target, imem_data,
      input  imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, hlt, fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage pipeline. Owns the PC, drives the
// instruction-memory address, latches the fetched word into IF/ID, honours
// stall/flush from the hazard and branch logic and freezes fetch when the
// halt opcode is fetched.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  fetch_stage_if.master (control inputs, imem port, IF/ID outputs,
//        hlt and fetch_count)
//
// Priority on each edge: rst > flush > stall > normal fetch.
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter int                ADDR_W     = 16,
   parameter int                INSTR_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
   parameter logic [3:0]        HLT_OPCODE = 4'hF
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [ADDR_W-1:0]  ifid_pc_plus2_q, ifid_pc_plus2_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [15:0]        fetch_count_q, fetch_count_d;
   logic               hlt_s;

   logic [ADDR_W-1:0]  pc_plus2_s;
   logic               is_halt_s;

   // Sequential PC increment wraps modulo 2^ADDR_W by construction.
   assign pc_plus2_s = pc_q + ADDR_W'(2);
   assign is_halt_s  = (bus.imem_data[INSTR_W-1 -: 4] == HLT_OPCODE);

   // State register: synchronous reset into RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: flush always returns to RUN; a halt word is only
   // recognised on an unstalled fetch while running.
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = ST_RUN;
      end else if (bus.stall) begin
         state_d = state_q;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (is_halt_s) begin
                  state_d = ST_HALTED;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
         endcase
      end
   end

   // Output decode of the FSM.
   always_comb begin
      hlt_s = 1'b0;
      case (state_q)
         ST_RUN:    hlt_s = 1'b0;
         ST_HALTED: hlt_s = 1'b1;
         default:   hlt_s = 1'b0;
      endcase
   end

   // Datapath next values: PC, IF/ID register and delivered-instruction count.
   always_comb begin
      pc_d            = pc_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_plus2_d = ifid_pc_plus2_q;
      ifid_valid_d    = ifid_valid_q;
      fetch_count_d   = fetch_count_q;
      if (bus.flush) begin
         // Redirect; whatever was fetched this cycle is on the wrong path.
         pc_d         = bus.branch_target;
         ifid_instr_d = '0;
         ifid_valid_d = 1'b0;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end else if (state_q == ST_RUN) begin
         ifid_instr_d    = bus.imem_data;
         ifid_pc_plus2_d = pc_plus2_s;
         ifid_valid_d    = 1'b1;
         if (fetch_count_q == 16'hFFFF) begin
            fetch_count_d = fetch_count_q;
         end else begin
            fetch_count_d = fetch_count_q + 16'd1;
         end
         // The halt word is delivered, but the PC parks on its address.
         if (is_halt_s) begin
            pc_d = pc_q;
         end else begin
            pc_d = pc_plus2_s;
         end
      end else begin
         // Halted: keep feeding bubbles to decode.
         ifid_instr_d = '0;
         ifid_valid_d = 1'b0;
      end
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q            <= RESET_PC;
         ifid_instr_q    <= '0;
         ifid_pc_plus2_q <= '0;
         ifid_valid_q    <= 1'b0;
         fetch_count_q   <= 16'h0000;
      end else begin
         pc_q            <= pc_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc_plus2_q <= ifid_pc_plus2_d;
         ifid_valid_q    <= ifid_valid_d;
         fetch_count_q   <= fetch_count_d;
      end
   end

   assign bus.imem_addr     = pc_q;
   assign bus.ifid_instr    = ifid_instr_q;
   assign bus.ifid_pc_plus2 = ifid_pc_plus2_q;
   assign bus.ifid_valid    = ifid_valid_q;
   assign bus.hlt           = hlt_s;
   assign bus.fetch_count   = fetch_count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the 5-stage pipelined CPU, sitting directly upstream of decode. It owns the program counter and drives the instruction-memory address. It latches the fetched word into the IF/ID pipeline register and honours stall and flush requests from the hazard/branch logic. It detects the halt opcode, freezes fetch, and raises the halt indication that the CPU exports as its halt output.

## Interface
- ADDR_W, 16, PC and memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, PC value after reset
- HLT_OPCODE, 4'hF, opcode in instr[INSTR_W-1 -: 4] that halts fetch
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID contents
- flush  in  1  branch taken in decode: redirect PC, squash IF/ID
- branch_target  in  ADDR_W  redirect address, valid when flush=1
- imem_addr  out  ADDR_W  instruction-memory address (= PC register)
- imem_data  in  INSTR_W  instruction word, combinational read of imem_addr
- ifid_instr  out  INSTR_W  registered instruction to decode
- ifid_pc_plus2  out  ADDR_W  registered PC+2 of that instruction
- ifid_valid  out  1  IF/ID holds a real instruction
- hlt  out  1  fetch halted (state HALTED)
- fetch_count  out  16  saturating count of instructions delivered with valid=1

## Operation
- State machine: RUN, HALTED. Reset enters RUN.
- Per-edge priority: rst > flush > stall > normal.
- rst: pc=RESET_PC; ifid_instr=0; ifid_pc_plus2=0; ifid_valid=0; fetch_count=0; state=RUN; hlt=0.
- flush (any state): pc<=branch_target; ifid_instr<=0; ifid_valid<=0; state<=RUN. A halt fetched on a squashed path is discarded. flush overrides a simultaneous stall.
- stall (no flush): pc, IF/ID, state, and fetch_count all hold. A halt opcode on imem_data is not recognised this cycle.
- RUN, normal: ifid_instr<=imem_data; ifid_pc_plus2<=pc+2; ifid_valid<=1; fetch_count increments.
  - If opcode==HLT_OPCODE: pc holds at the halt address and state<=HALTED. The halt instruction itself is delivered with valid=1 so it drains down the pipe.
  - Otherwise: pc<=pc+2.
- HALTED, normal: pc holds; ifid_valid<=0 (bubbles); ifid_instr<=0; fetch_count holds. Only rst or flush leaves HALTED.
- Arithmetic: pc+2 is modulo 2^ADDR_W, so 16'hFFFE wraps to 16'h0000. branch_target is used unmodified; bit 0 is not masked.
- fetch_count saturates at 16'hFFFF and does not wrap.

## Timing
- imem_addr is combinational from the PC register; no added delay.
- IF/ID outputs are registered: an instruction at PC=A appears on ifid_instr one edge after A is on imem_addr.
- Redirect latency: flush at edge N puts branch_target on imem_addr after N. The target instruction is valid in IF/ID after N+1. Exactly one bubble is inserted.
- hlt rises on the same edge that latches the halt instruction into IF/ID and stays high until rst or flush.
- stall holds for any number of cycles. Releasing it resumes with no lost or duplicated fetch.
- Reset deasserted mid-operation: the first edge with rst=0 fetches from RESET_PC.

## Test plan
- Reset, then imem returns 16'h1000,16'h2000,... sequentially -> imem_addr 0,2,4,6; ifid_pc_plus2 2,4,6,8; ifid_valid=1 from the second edge; fetch_count=4 after 4 fetches.
- Stall for 3 cycles at PC=4 -> imem_addr stays 4; ifid_instr/ifid_pc_plus2 unchanged; fetch_count unchanged. Release -> next edge latches the word at 4, pc=6.
- Flush with branch_target=16'h0040 while stall=1 -> imem_addr=16'h0040 next cycle; ifid_valid=0 for one cycle; then the instruction at 0x40 with pc_plus2=16'h0042.
- imem_data=16'hF000 at PC=8 -> IF/ID gets F000 with valid=1 and hlt=1. imem_addr stays 8 indefinitely, ifid_valid=0 afterwards, and fetch_count stops.
- While HALTED, flush with target 16'h0010 -> hlt=0 and fetch resumes at 0x10. Separately, rst while HALTED -> all outputs return to reset values.
- pc=16'hFFFE with a non-halt word -> next imem_addr=16'h0000 and ifid_pc_plus2=16'h0000.
